// File: rtl/sap_ctrl_pkg.sv
// Shared SAP control definitions: ctrl bit map, opcodes, T-states,
// fixed control words and the opcode/T-state decode ROM.
package sap_ctrl_pkg;

  localparam int OPCODE_W = 4;
  localparam int T_W      = 3;
  localparam int CTRL_W   = 16;

  localparam int CB_PC_OUT   = 0;
  localparam int CB_PC_INC   = 1;
  localparam int CB_PC_LOAD  = 2;
  localparam int CB_MAR_WR   = 3;
  localparam int CB_RAM_OUT  = 4;
  localparam int CB_RAM_WR   = 5;
  localparam int CB_IR_WR    = 6;
  localparam int CB_IR_OUT   = 7;
  localparam int CB_A_WR     = 8;
  localparam int CB_A_OUT    = 9;
  localparam int CB_B_WR     = 10;
  localparam int CB_ALU_OUT  = 11;
  localparam int CB_ALU_SUB  = 12;
  localparam int CB_FLAGS_WR = 13;
  localparam int CB_OUT_WR   = 14;
  localparam int CB_RSVD     = 15;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t M_PC_OUT   = ctrl_t'(1) << CB_PC_OUT;
  localparam ctrl_t M_PC_INC   = ctrl_t'(1) << CB_PC_INC;
  localparam ctrl_t M_PC_LOAD  = ctrl_t'(1) << CB_PC_LOAD;
  localparam ctrl_t M_MAR_WR   = ctrl_t'(1) << CB_MAR_WR;
  localparam ctrl_t M_RAM_OUT  = ctrl_t'(1) << CB_RAM_OUT;
  localparam ctrl_t M_RAM_WR   = ctrl_t'(1) << CB_RAM_WR;
  localparam ctrl_t M_IR_WR    = ctrl_t'(1) << CB_IR_WR;
  localparam ctrl_t M_IR_OUT   = ctrl_t'(1) << CB_IR_OUT;
  localparam ctrl_t M_A_WR     = ctrl_t'(1) << CB_A_WR;
  localparam ctrl_t M_A_OUT    = ctrl_t'(1) << CB_A_OUT;
  localparam ctrl_t M_B_WR     = ctrl_t'(1) << CB_B_WR;
  localparam ctrl_t M_ALU_OUT  = ctrl_t'(1) << CB_ALU_OUT;
  localparam ctrl_t M_ALU_SUB  = ctrl_t'(1) << CB_ALU_SUB;
  localparam ctrl_t M_FLAGS_WR = ctrl_t'(1) << CB_FLAGS_WR;
  localparam ctrl_t M_OUT_WR   = ctrl_t'(1) << CB_OUT_WR;

  // Bits that drive the shared bus
  localparam ctrl_t M_BUS =
    M_PC_OUT | M_RAM_OUT | M_IR_OUT | M_A_OUT | M_ALU_OUT;

  // Register load strobes, gated off while waiting for a step
  localparam ctrl_t M_WRITES =
    M_PC_INC | M_PC_LOAD | M_MAR_WR | M_RAM_WR | M_IR_WR |
    M_A_WR | M_B_WR | M_FLAGS_WR | M_OUT_WR;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h3,
    OP_LDI = 4'h4,
    OP_JMP = 4'h5,
    OP_JZ  = 4'h6,
    OP_JC  = 4'h7,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } op_e;

  typedef logic [T_W-1:0] tstate_t;

  localparam tstate_t T0 = 3'd0;
  localparam tstate_t T1 = 3'd1;
  localparam tstate_t T2 = 3'd2;
  localparam tstate_t T3 = 3'd3;
  localparam tstate_t T4 = 3'd4;
  localparam tstate_t T5 = 3'd5;

  localparam ctrl_t CW_FETCH0 = M_PC_OUT | M_MAR_WR;
  localparam ctrl_t CW_FETCH1 = M_RAM_OUT | M_IR_WR | M_PC_INC;
  localparam ctrl_t CW_IR_MAR = M_IR_OUT | M_MAR_WR;
  localparam ctrl_t CW_RAM_A  = M_RAM_OUT | M_A_WR;
  localparam ctrl_t CW_RAM_B  = M_RAM_OUT | M_B_WR;
  localparam ctrl_t CW_A_RAM  = M_A_OUT | M_RAM_WR;
  localparam ctrl_t CW_IR_A   = M_IR_OUT | M_A_WR;
  localparam ctrl_t CW_JUMP   = M_IR_OUT | M_PC_LOAD;
  localparam ctrl_t CW_A_OUTR = M_A_OUT | M_OUT_WR;
  localparam ctrl_t CW_ALU_A  = M_ALU_OUT | M_A_WR | M_FLAGS_WR;

  typedef struct packed {
    ctrl_t cw;
    logic  last;
  } dec_t;

  // last marks the final T-state of the instruction
  function automatic dec_t sap_decode(
    input tstate_t              t,
    input logic [OPCODE_W-1:0]  op,
    input logic                 z,
    input logic                 c
  );
    dec_t d;
    d.cw   = '0;
    d.last = 1'b0;
    case (t)
      T0: d.cw = CW_FETCH0;
      T1: d.cw = CW_FETCH1;
      T2: begin
        d.last = 1'b1;
        case (op)
          OP_LDA, OP_ADD,
          OP_SUB, OP_STA: begin
            d.cw   = CW_IR_MAR;
            d.last = 1'b0;
          end
          OP_LDI: d.cw = CW_IR_A;
          OP_JMP: d.cw = CW_JUMP;
          OP_JZ:  d.cw = z ? CW_JUMP : '0;
          OP_JC:  d.cw = c ? CW_JUMP : '0;
          OP_OUT: d.cw = CW_A_OUTR;
          default: d.cw = '0;
        endcase
      end
      T3: begin
        d.last = 1'b1;
        case (op)
          OP_LDA: d.cw = CW_RAM_A;
          OP_ADD, OP_SUB: begin
            d.cw   = CW_RAM_B;
            d.last = 1'b0;
          end
          OP_STA: d.cw = CW_A_RAM;
          default: d.cw = '0;
        endcase
      end
      T4: begin
        d.last = 1'b1;
        case (op)
          OP_ADD: d.cw = CW_ALU_A;
          OP_SUB: d.cw = CW_ALU_A | M_ALU_SUB;
          default: d.cw = '0;
        endcase
      end
      // Unreachable states fall back to fetch
      default: d.last = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sap_tstate_ring.sv
// T-state counter: advances on adv_en, reloads T0 after the last state
// of an instruction, held at T0 while frozen. Ports: clk, rst, adv_en, last, freeze, t_o.
module sap_tstate_ring
  import sap_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    adv_en,
  input  logic    last,
  input  logic    freeze,
  output tstate_t t_o
);

  tstate_t t_q;
  tstate_t t_d;

  always_comb begin
    t_d = t_q;
    if (freeze) begin
      t_d = T0;
    end else if (adv_en) begin
      t_d = last ? T0 : t_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q <= T0;
    end else begin
      t_q <= t_d;
    end
  end

  assign t_o = t_q;

endmodule

// File: rtl/sap_control_seq.sv
// SAP microsequencer: steps T-states and decodes IR opcode into ctrl.
// Ports: clk, rst, ir_opcode, zero_flag, carry_flag, [step], ctrl, t_state, halted.
// Macro SINGLE_STEP_EN adds the step port and step-gated advance.
module sap_control_seq
  import sap_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                zero_flag,
  input  logic                carry_flag,
`ifdef SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic [CTRL_W-1:0]   ctrl,
  output logic [T_W-1:0]      t_state,
  output logic                halted
);

  tstate_t t_q;
  logic    halted_q;
  logic    halted_d;
  logic    adv;
  dec_t    dec;

`ifdef SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  sap_tstate_ring u_ring (
    .clk    (clk),
    .rst    (rst),
    .adv_en (adv),
    .last   (dec.last),
    .freeze (halted_q),
    .t_o    (t_q)
  );

  always_comb begin
    dec = sap_decode(t_q, ir_opcode,
                     zero_flag, carry_flag);
  end

  // Halt latches at the end of HLT T2; only rst clears it
  always_comb begin
    halted_d = halted_q;
    if (adv && t_q == T2 &&
        ir_opcode == OP_HLT) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Bus drivers stay up while waiting; loads wait for the step
  always_comb begin
    ctrl = dec.cw;
    if (!adv) begin
      ctrl = dec.cw & ~M_WRITES;
    end
    if (rst || halted_q) begin
      ctrl = '0;
    end
  end

  assign t_state = t_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_sap_control_seq.sv
// Directed bench for sap_control_seq: fetch/execute words per opcode,
// conditional jumps, halt, mid-instruction reset, optional single-step.
module tb_sap_control_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ir_opcode;
  logic        zero_flag;
  logic        carry_flag;
  logic        step;
  logic [15:0] ctrl;
  logic [2:0]  t_state;
  logic        halted;
  logic        mon_en;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [15:0] BUSM = 16'h0A91;

  always #5 clk = ~clk;

  sap_control_seq dut (
    .clk        (clk),
    .rst        (rst),
    .ir_opcode  (ir_opcode),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
`ifdef SINGLE_STEP_EN
    .step       (step),
`endif
    .ctrl       (ctrl),
    .t_state    (t_state),
    .halted     (halted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("bus1h", 32'($countones(ctrl & BUSM) <= 1), 32'd1);
      chk("bit15", 32'(ctrl[15]), 32'd0);
    end
  end

  task automatic run_ins(input string tag,
                         input logic [3:0] op,
                         input logic z, input logic c,
                         input int n,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3,
                         input logic [15:0] w4);
    logic [15:0] w [5];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
    ir_opcode  = op;
    zero_flag  = z;
    carry_flag = c;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_cw_t%0d", tag, k), 32'(ctrl), 32'(w[k]));
      chk($sformatf("%s_t%0d", tag, k), 32'(t_state), k);
      tick();
    end
    chk({tag, "_end_t"}, 32'(t_state), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ir_opcode = 4'h0; zero_flag = 1'b0;
    carry_flag = 1'b0; step = 1'b1; mon_en = 1'b0;
    tick(); tick();
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_t", 32'(t_state), 32'd0);
    chk("rst_halt", 32'(halted), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("post_rst_cw", 32'(ctrl), 32'h0009);

    run_ins("LDA", 4'h0, 0, 0, 4, 16'h0009, 16'h0052, 16'h0088, 16'h0110, 16'h0);
    chk("LDA_next_cw", 32'(ctrl), 32'h0009);
    run_ins("ADD", 4'h1, 0, 0, 5, 16'h0009, 16'h0052, 16'h0088, 16'h0410, 16'h2900);
    run_ins("SUB", 4'h2, 0, 0, 5, 16'h0009, 16'h0052, 16'h0088, 16'h0410, 16'h3900);
    run_ins("STA", 4'h3, 0, 0, 4, 16'h0009, 16'h0052, 16'h0088, 16'h0220, 16'h0);
    run_ins("LDI", 4'h4, 0, 0, 3, 16'h0009, 16'h0052, 16'h0180, 16'h0, 16'h0);
    run_ins("JMP", 4'h5, 0, 0, 3, 16'h0009, 16'h0052, 16'h0084, 16'h0, 16'h0);
    run_ins("JZ0", 4'h6, 0, 1, 3, 16'h0009, 16'h0052, 16'h0000, 16'h0, 16'h0);
    run_ins("JZ1", 4'h6, 1, 0, 3, 16'h0009, 16'h0052, 16'h0084, 16'h0, 16'h0);
    run_ins("JC0", 4'h7, 1, 0, 3, 16'h0009, 16'h0052, 16'h0000, 16'h0, 16'h0);
    run_ins("JC1", 4'h7, 0, 1, 3, 16'h0009, 16'h0052, 16'h0084, 16'h0, 16'h0);
    run_ins("OUT", 4'hE, 0, 0, 3, 16'h0009, 16'h0052, 16'h4200, 16'h0, 16'h0);
    run_ins("NOP", 4'h9, 0, 0, 3, 16'h0009, 16'h0052, 16'h0000, 16'h0, 16'h0);

    // Reset during ADD T3
    ir_opcode = 4'h1;
    tick(); tick(); tick();
    chk("mid_t3", 32'(t_state), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_cw", 32'(ctrl), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_post_cw", 32'(ctrl), 32'h0009);
    chk("mid_post_t", 32'(t_state), 32'd0);

    run_ins("HLT", 4'hF, 0, 0, 3, 16'h0009, 16'h0052, 16'h0000, 16'h0, 16'h0);
    chk("hlt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      ir_opcode  = 4'($urandom);
      zero_flag  = 1'($urandom);
      carry_flag = 1'($urandom);
`ifdef SINGLE_STEP_EN
      step = 1'($urandom);
`endif
      #1;
      chk("hlt_cw", 32'(ctrl), 32'h0);
      chk("hlt_t", 32'(t_state), 32'd0);
      chk("hlt_hold", 32'(halted), 32'd1);
      tick();
    end
    step = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ir_opcode = 4'h0;
    #1;
    chk("unhlt_flag", 32'(halted), 32'd0);
    chk("unhlt_cw", 32'(ctrl), 32'h0009);
    chk("unhlt_t", 32'(t_state), 32'd0);

`ifdef SINGLE_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("ss_wait_cw", 32'(ctrl), 32'h0001);
      chk("ss_wait_t", 32'(t_state), 32'd0);
      tick();
    end
    step = 1'b1;
    #1;
    chk("ss_go_cw", 32'(ctrl), 32'h0009);
    tick();
    step = 1'b0;
    #1;
    chk("ss_t1", 32'(t_state), 32'd1);
    chk("ss_t1_cw", 32'(ctrl), 32'h0010);
    step = 1'b1;
    tick();
    chk("ss_t2", 32'(t_state), 32'd2);
`endif

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
